episode_tracker: RTL and testbench
==================================

// Module: episode_tracker
// PURPOSE
//   Upstream stage of the metacognition monitor. Tracks which pattern ID wins
//   each theta window and keeps a 4-bit saturating stability score for the
//   current episode. Drives ep_strength/ep_valid, which metacognition samples
//   on theta_tick. Repeats strengthen the episode; competing or absent
//   patterns weaken it, and can replace or clear it.
// PARAMETERS
//   ID_W        4   width of pattern ID
//   STR_MAX     15  strength saturation ceiling (1..15)
//   INC         1   strength gain on a matching window
//   DECAY       2   strength loss on a mismatching window
//   CAPTURE_STR 1   strength given to a newly captured episode (1..STR_MAX)
//   MISS_LIMIT  3   consecutive empty windows that clear the episode (1..7)
// PORTS
//   clk          in   1     clock
//   rst          in   1     synchronous reset, active-high
//   theta_tick   in   1     1-cycle pulse closing the current theta window
//   pat_valid    in   1     winner pattern present this cycle
//   pat_id       in   ID_W  winner pattern ID, qualified by pat_valid
//   ep_strength  out  4     current episode stability (registered)
//   ep_valid     out  1     an episode is held (registered)
//   ep_id        out  ID_W  ID of held episode (registered)
//   ep_update    out  1     1-cycle pulse: window evaluated, outputs refreshed
//   ep_conflict  out  1     last window saw >=2 distinct IDs (registered)
// BEHAVIOUR
//   Reset (rst=1 at posedge): all outputs 0, miss_cnt=0, window empty, state EMPTY.
//   Window capture: first pat_valid in a window latches win_id and sets win_seen.
//     Later pat_valid with a different ID sets win_conf; the same ID is ignored.
//   theta_tick and pat_valid in the same cycle: the pattern belongs to the NEW
//     window. The closing window is evaluated with its prior contents. The new
//     window is then initialised with that pattern (win_seen=1).
//   Evaluation happens on the theta_tick clock edge. Outputs and ep_update=1 are
//     visible in the next cycle. Outputs then hold until the next evaluation.
//   ep_conflict is loaded from win_conf at each evaluation.
//   States: EMPTY (ep_valid=0), HOLD (ep_valid=1).
//   EMPTY, win_seen:  ep_id<=win_id, strength<=CAPTURE_STR, miss_cnt<=0; go to HOLD.
//   EMPTY, !win_seen: no change (ep_update still pulses).
//   HOLD, win_seen, win_id==ep_id:
//     strength <= min(strength+INC, STR_MAX), using 5-bit intermediate; miss_cnt<=0.
//   HOLD, win_seen, win_id!=ep_id:
//     s = strength-DECAY, saturating at 0; miss_cnt<=0.
//     If s==0: ep_id<=win_id, strength<=CAPTURE_STR (replacement, stay in HOLD).
//     Else: strength<=s.
//   HOLD, !win_seen: miss_cnt++ and strength <= sat-sub 1.
//     If the new miss_cnt==MISS_LIMIT or the new strength==0: go to EMPTY,
//     strength<=0, ep_id<=0, miss_cnt<=0.
//   ep_strength is never >STR_MAX and never wraps, in either direction.
//   Reset mid-window discards the partial window; the first tick after reset
//     evaluates only patterns seen since reset.
// TESTING
//   1: rst, then pat 5 in 3 consecutive windows (INC=1)
//      -> after ticks: str 1,2,3; ep_id=5; ep_valid=1; ep_update pulse each tick.
//   2: 20 windows of pat 5 -> strength saturates at 15 and never wraps to 0.
//   3: strength=3 on id 5, then one window of id 9 -> str 1, id 5;
//      a second window of id 9 -> str 0, replaced: id 9, str 1.
//   4: strength=10 on id 5, then 3 empty windows -> str 9, 8, then EMPTY:
//      ep_valid=0, str 0.
//   5: pat 7 then pat 2 in one window -> evaluated as 7; ep_conflict=1.
//      pat_valid(3) on the theta_tick cycle counts toward the next window.
//   6: rst asserted mid-window after pat 4 in HOLD str 6
//      -> all outputs 0 next cycle; the following tick with no pattern keeps EMPTY.

Source files
------------

// File: rtl/episode_tracker.sv
// rtl/episode_tracker.sv - per-theta-window winner tracking with a saturating episode stability score
module episode_tracker #(
  parameter int ID_W        = 4,
  parameter int STR_MAX     = 15,
  parameter int INC         = 1,
  parameter int DECAY       = 2,
  parameter int CAPTURE_STR = 1,
  parameter int MISS_LIMIT  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            theta_tick,
  input  logic            pat_valid,
  input  logic [ID_W-1:0] pat_id,
  output logic [3:0]      ep_strength,
  output logic            ep_valid,
  output logic [ID_W-1:0] ep_id,
  output logic            ep_update,
  output logic            ep_conflict
);

  localparam logic [4:0] LP_INC     = 5'(INC);
  localparam logic [4:0] LP_MAX5    = 5'(STR_MAX);
  localparam logic [3:0] LP_MAX4    = 4'(STR_MAX);
  localparam logic [3:0] LP_DECAY   = 4'(DECAY);
  localparam logic [3:0] LP_CAPTURE = 4'(CAPTURE_STR);
  localparam logic [2:0] LP_MISS    = 3'(MISS_LIMIT);

  typedef enum logic {ST_EMPTY, ST_HOLD} state_t;

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_str, w_str_nxt;
  logic [ID_W-1:0] r_ep_id, w_id_nxt;
  logic [2:0]      r_miss, w_miss_nxt;
  logic            r_win_seen, r_win_conf;
  logic [ID_W-1:0] r_win_id;
  logic            r_update, r_conflict;

  logic [4:0]      w_sum;
  logic [3:0]      w_dec, w_str_m1;
  logic [2:0]      w_miss_inc;

  always_comb begin
    w_state_nxt = r_state;
    w_str_nxt   = r_str;
    w_id_nxt    = r_ep_id;
    w_miss_nxt  = r_miss;
    w_sum       = {1'b0, r_str} + LP_INC;
    w_dec       = (r_str > LP_DECAY) ? (r_str - LP_DECAY) : 4'd0;
    w_str_m1    = (r_str != 4'd0) ? (r_str - 4'd1) : 4'd0;
    w_miss_inc  = r_miss + 3'd1;
    case (r_state)
      ST_EMPTY: begin
        if (r_win_seen) begin
          w_id_nxt    = r_win_id;
          w_str_nxt   = LP_CAPTURE;
          w_miss_nxt  = 3'd0;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (r_win_seen) begin
          w_miss_nxt = 3'd0;
          if (r_win_id == r_ep_id) begin
            w_str_nxt = (w_sum > LP_MAX5) ? LP_MAX4 : w_sum[3:0];
          end else if (w_dec == 4'd0) begin
            // Competitor wore the episode down to nothing: it takes over.
            w_id_nxt  = r_win_id;
            w_str_nxt = LP_CAPTURE;
          end else begin
            w_str_nxt = w_dec;
          end
        end else begin
          w_miss_nxt = w_miss_inc;
          w_str_nxt  = w_str_m1;
          if (w_miss_inc == LP_MISS || w_str_m1 == 4'd0) begin
            w_state_nxt = ST_EMPTY;
            w_str_nxt   = 4'd0;
            w_id_nxt    = '0;
            w_miss_nxt  = 3'd0;
          end
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_str      <= 4'd0;
      r_ep_id    <= '0;
      r_miss     <= 3'd0;
      r_win_seen <= 1'b0;
      r_win_conf <= 1'b0;
      r_win_id   <= '0;
      r_update   <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_update <= theta_tick;
      if (theta_tick) begin
        r_state    <= w_state_nxt;
        r_str      <= w_str_nxt;
        r_ep_id    <= w_id_nxt;
        r_miss     <= w_miss_nxt;
        r_conflict <= r_win_conf;
        // A pattern on the tick cycle opens the next window.
        r_win_seen <= pat_valid;
        r_win_id   <= pat_valid ? pat_id : '0;
        r_win_conf <= 1'b0;
      end else if (pat_valid) begin
        if (!r_win_seen) begin
          r_win_seen <= 1'b1;
          r_win_id   <= pat_id;
        end else if (pat_id != r_win_id) begin
          r_win_conf <= 1'b1;
        end
      end
    end
  end

  assign ep_strength = r_str;
  assign ep_valid    = (r_state == ST_HOLD);
  assign ep_id       = r_ep_id;
  assign ep_update   = r_update;
  assign ep_conflict = r_conflict;

endmodule

// File: tb/tb_episode_tracker.sv
// tb/tb_episode_tracker.sv - directed self-checking bench for episode_tracker
module tb_episode_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       theta_tick = 1'b0;
  logic       pat_valid = 1'b0;
  logic [3:0] pat_id = 4'd0;
  logic [3:0] ep_strength;
  logic       ep_valid;
  logic [3:0] ep_id;
  logic       ep_update;
  logic       ep_conflict;

  int n_checks = 0;
  int n_fail   = 0;

  episode_tracker dut (
    .clk        (clk),
    .rst        (rst),
    .theta_tick (theta_tick),
    .pat_valid  (pat_valid),
    .pat_id     (pat_id),
    .ep_strength(ep_strength),
    .ep_valid   (ep_valid),
    .ep_id      (ep_id),
    .ep_update  (ep_update),
    .ep_conflict(ep_conflict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; theta_tick = 1'b0; pat_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One pattern cycle (optional), then a tick cycle; returns at the negedge where results are visible.
  task automatic window(input logic v, input logic [3:0] id);
    @(negedge clk);
    pat_valid = v; pat_id = id; theta_tick = 1'b0;
    @(negedge clk);
    pat_valid = 1'b0; theta_tick = 1'b1;
    @(negedge clk);
    theta_tick = 1'b0;
  endtask

  task automatic expect_ep(input string tag, input int s, input int v, input int id);
    check({tag, "_str"}, int'(ep_strength), s);
    check({tag, "_valid"}, int'(ep_valid), v);
    check({tag, "_id"}, int'(ep_id), id);
  endtask

  initial begin
    do_reset();
    expect_ep("rst", 0, 0, 0);
    check("rst_update", int'(ep_update), 0);
    check("rst_conflict", int'(ep_conflict), 0);

    // 1: three matching windows
    for (int k = 1; k <= 3; k++) begin
      window(1'b1, 4'd5);
      expect_ep($sformatf("t1_w%0d", k), k, 1, 5);
      check($sformatf("t1_upd%0d", k), int'(ep_update), 1);
    end
    @(negedge clk);
    check("t1_upd_drop", int'(ep_update), 0);
    check("t1_hold_str", int'(ep_strength), 3);

    // 2: saturation at 15
    for (int k = 4; k <= 20; k++) begin
      window(1'b1, 4'd5);
      check($sformatf("t2_str%0d", k), int'(ep_strength), (k > 15) ? 15 : k);
    end
    check("t2_valid", int'(ep_valid), 1);

    // 3: decay then replacement
    do_reset();
    for (int k = 0; k < 3; k++) window(1'b1, 4'd5);
    check("t3_pre", int'(ep_strength), 3);
    window(1'b1, 4'd9);
    expect_ep("t3_decay", 1, 1, 5);
    window(1'b1, 4'd9);
    expect_ep("t3_repl", 1, 1, 9);

    // 4: empty windows clear after the miss limit
    do_reset();
    for (int k = 0; k < 10; k++) window(1'b1, 4'd5);
    check("t4_pre", int'(ep_strength), 10);
    window(1'b0, 4'd0);
    expect_ep("t4_miss1", 9, 1, 5);
    window(1'b0, 4'd0);
    expect_ep("t4_miss2", 8, 1, 5);
    window(1'b0, 4'd0);
    expect_ep("t4_miss3", 0, 0, 0);

    // 5: conflict window, and a pattern on the tick cycle opening the next window
    do_reset();
    @(negedge clk);
    pat_valid = 1'b1; pat_id = 4'd7;
    @(negedge clk);
    pat_id = 4'd2;
    @(negedge clk);
    pat_id = 4'd3; theta_tick = 1'b1;
    @(negedge clk);
    pat_valid = 1'b0; theta_tick = 1'b0;
    expect_ep("t5_cap", 1, 1, 7);
    check("t5_conf", int'(ep_conflict), 1);
    @(negedge clk);
    theta_tick = 1'b1;
    @(negedge clk);
    theta_tick = 1'b0;
    expect_ep("t5_next", 1, 1, 3);
    check("t5_conf_clr", int'(ep_conflict), 0);

    // 6: reset mid-window discards the partial window
    do_reset();
    for (int k = 0; k < 6; k++) window(1'b1, 4'd4);
    check("t6_pre", int'(ep_strength), 6);
    @(negedge clk);
    pat_valid = 1'b1; pat_id = 4'd4;
    @(negedge clk);
    pat_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expect_ep("t6_rst", 0, 0, 0);
    check("t6_rst_upd", int'(ep_update), 0);
    window(1'b0, 4'd0);
    expect_ep("t6_tick", 0, 0, 0);
    check("t6_tick_upd", int'(ep_update), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
